// File: rtl/mig_app_tester.sv
// mig_app_tester: DDR3 write/read/compare traffic generator on the MIG app interface.
// Define MIG_TESTER_ERR_INJECT_EN to build the write-data error-injection path.
module mig_app_tester #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 256,
  parameter int ADDR_STEP = 8,
  parameter int NUM_BURSTS = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic                      ui_clk,
  input  logic                      rst,
  input  logic                      calib_done,
  input  logic                      start,
  input  logic                      loop,
  input  logic [1:0]                mode,
  input  logic [31:0]               seed,
  input  logic                      inject_err,
  output logic [APP_ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]                app_cmd,
  output logic                      app_en,
  input  logic                      app_rdy,
  output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
  output logic                      app_wdf_wren,
  output logic                      app_wdf_end,
  input  logic                      app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
  input  logic                      app_rd_data_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic [15:0]               err_count,
  output logic [APP_ADDR_WIDTH-1:0] first_err_addr,
  output logic [15:0]               pass_count
);
  localparam int AW = APP_ADDR_WIDTH;
  localparam int DW = APP_DATA_WIDTH;
  localparam logic [16:0] NB = 17'(NUM_BURSTS);
  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);
  localparam logic [AW-1:0] STEP = AW'(ADDR_STEP);
  localparam logic [31:0] TAPS = 32'h80200003;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  state_t state;
  logic [1:0] md, ls_mode;
  logic [31:0] sd, lw, lr, ls_seed, l0, lw_n, lr_n;
  logic [16:0] wc, wd, rc;
  logic [AW-1:0] wa, ra;
  logic [DW-1:0] wdat, d0, wd_pat, rd_pat;
  logic launch, cacc, wacc, rval;
  function automatic logic [31:0] step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? TAPS : 32'd0);
  endfunction
  function automatic logic [DW-1:0] pat(input logic [1:0] m, input logic [31:0] s, input logic [31:0] l,
                                        input logic [16:0] i, input logic [AW-1:0] a);
    logic [DW-1:0] p;
    logic [31:0] a32;
    a32 = 32'(a);
    p = '0;
    for (int k = 0; k < DW / 32; k++)
      p[k*32 +: 32] = m == 2'd0 ? a32 + 32'(k) :
                      m == 2'd1 ? l ^ (32'h01010101 * 32'(k)) :
                      m == 2'd2 ? 32'd1 << 5'(i[4:0] + 5'(k)) :
                      (i[0] ^ k[0]) ? ~s : s;
    return p;
  endfunction
  always_comb begin
    launch = (state == IDLE && start && calib_done) || (state == DRAIN && rc == NB && loop);
    ls_mode = state == IDLE ? mode : md;
    ls_seed = state == IDLE ? seed : sd + 32'd1;
    l0 = ls_seed == 32'd0 ? 32'd1 : ls_seed;
    d0 = pat(ls_mode, ls_seed, l0, 17'd0, BASE);
    cacc = app_en && app_rdy;
    wacc = app_wdf_wren && app_wdf_rdy;
    rval = app_rd_data_valid && (state == READ || state == DRAIN) && rc != NB;
    lw_n = step(lw);
    lr_n = step(lr);
    wd_pat = pat(md, sd, lw_n, wd + 17'd1, wa + STEP);
    rd_pat = pat(md, sd, lr, rc, ra);
  end
  always_ff @(posedge ui_clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      {md, sd, lw, lr, wc, wd, rc, wa, ra, wdat} <= '0;
      {app_en, app_cmd, app_addr, app_wdf_wren} <= '0;
      {busy, done, pass, fail, err_count, first_err_addr, pass_count} <= '0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        state <= WRITE;
        busy <= 1'b1;
        md <= ls_mode;
        sd <= ls_seed;
        lw <= l0;
        lr <= l0;
        {wc, wd, rc} <= '0;
        wa <= BASE;
        ra <= BASE;
        app_en <= 1'b1;
        app_cmd <= 3'b000;
        app_addr <= BASE;
        app_wdf_wren <= 1'b1;
        wdat <= d0;
      end
      if (launch && state == IDLE)
        {pass, fail, err_count, first_err_addr, pass_count} <= '0;
      if (cacc) begin
        wc <= wc + 17'd1;
        app_addr <= app_addr + STEP;
        if (wc + 17'd1 == NB) begin
          app_en <= 1'b0;
          if (state == READ) state <= DRAIN;
        end
      end
      if (wacc) begin
        wd <= wd + 17'd1;
        wa <= wa + STEP;
        lw <= lw_n;
        wdat <= wd_pat;
        if (wd + 17'd1 == NB) app_wdf_wren <= 1'b0;
      end
      if (state == WRITE && wc == NB && wd == NB) begin
        state <= READ;
        app_en <= 1'b1;
        app_cmd <= 3'b001;
        app_addr <= BASE;
        wc <= '0;
      end
      // reads return in issue order, so rc/ra/lr track the beat being checked
      if (rval) begin
        rc <= rc + 17'd1;
        ra <= ra + STEP;
        lr <= lr_n;
        if (app_rd_data != rd_pat) begin
          err_count <= err_count + 16'(err_count != 16'hFFFF);
          if (!fail) begin
            fail <= 1'b1;
            first_err_addr <= ra;
          end
        end
      end
      if (state == DRAIN && rc == NB) begin
        done <= 1'b1;
        pass_count <= pass_count + 16'd1;
        if (err_count == 16'd0) pass <= 1'b1;
        if (!loop) begin
          state <= IDLE;
          busy <= 1'b0;
        end
      end
    end
  assign app_wdf_end = app_wdf_wren;
`ifdef MIG_TESTER_ERR_INJECT_EN
  logic pend;
  always_ff @(posedge ui_clk or posedge rst)
    if (rst) pend <= 1'b0;
    else pend <= inject_err || (pend && !wacc);
  assign app_wdf_data = wdat ^ DW'(pend);
`else
  logic unused_inject;
  assign unused_inject = inject_err;
  assign app_wdf_data = wdat;
`endif
endmodule
